// File: rtl/breakout_audio_pkg.sv
// Shared types, constants and tone lookup helpers for the breakout sound-effect path.
package breakout_audio_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned HP_W     = 7;
  localparam int unsigned CNT_W    = 15;
  localparam int unsigned ATT_W    = 3;
  localparam int unsigned N_EVT    = 4;

  localparam logic signed [SAMPLE_W-1:0] AMP = 24'sd1048576;

  localparam int unsigned HP_WALL   = 12;
  localparam int unsigned HP_BRICK  = 24;
  localparam int unsigned HP_PADDLE = 48;
  localparam int unsigned HP_LOSE   = 120;
  localparam int unsigned SUSTAIN   = 4800;
  localparam int unsigned REL_STEP  = 480;
  localparam int unsigned ATT_MAX   = 4;

  // Enum order doubles as event priority (higher value wins).
  typedef enum logic [2:0] {
    SFX_NONE,
    SFX_WALL,
    SFX_BRICK,
    SFX_PADDLE,
    SFX_LOSE
  } sfx_e;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } sfx_state_e;

  // Square-wave half period in accepted samples.
  function automatic logic [HP_W-1:0] half_period(input sfx_e s);
    case (s)
      SFX_WALL:   return HP_W'(HP_WALL);
      SFX_BRICK:  return HP_W'(HP_BRICK);
      SFX_PADDLE: return HP_W'(HP_PADDLE);
      SFX_LOSE:   return HP_W'(HP_LOSE);
      default:    return HP_W'(HP_WALL);
    endcase
  endfunction

  // Full-level sustain length in accepted samples.
  function automatic logic [CNT_W-1:0] sustain_len(input sfx_e s);
    if (s == SFX_LOSE) return CNT_W'(4 * SUSTAIN);
    return CNT_W'(SUSTAIN);
  endfunction

endpackage

// File: rtl/sfx_tone_gen_osc.sv
// sfx_square_osc: square-wave oscillator with attenuation shift.
//  clk, reset   clock, synchronous active-high reset
//  restart      force phase 0, positive polarity
//  adv          one accepted sample; advance phase
//  hp           half period in samples
//  att          attenuation (right shift) applied to the next sample
//  sample_c     sample that will be current after this clock edge
module sfx_square_osc
  import breakout_audio_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       adv,
  input  logic [HP_W-1:0]            hp,
  input  logic [ATT_W-1:0]           att,
  output logic signed [SAMPLE_W-1:0] sample_c
);

  logic [HP_W-1:0]            phase, phase_n;
  logic                       pol, pol_n;
  logic signed [SAMPLE_W-1:0] level;

  // Phase wraps at hp-1 and flips polarity.
  always_comb begin
    phase_n = phase;
    pol_n   = pol;
    if (restart) begin
      phase_n = '0;
      pol_n   = 1'b1;
    end else if (adv) begin
      if (phase == hp - HP_W'(1)) begin
        phase_n = '0;
        pol_n   = ~pol;
      end else begin
        phase_n = phase + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      pol   <= 1'b0;
    end else begin
      phase <= phase_n;
      pol   <= pol_n;
    end
  end

  // Sample is built from next-state polarity so the top can register it.
  always_comb begin
    level    = AMP >>> att;
    sample_c = pol_n ? level : -level;
  end

endmodule

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: converts game events into square-wave tones for the codec DAC port.
//  clk, reset                  clock, synchronous active-high reset
//  evt_wall/brick/paddle/lose  level event inputs, rising edge fires
//  mute                        force zero samples, timing unaffected
//  write_ready                 codec accepts a sample this cycle
//  write                       sample valid (write_ready & ~reset)
//  writedata_left/right        signed 24-bit sample, right mirrors left
//  busy                        tone in progress
module sfx_tone_gen
  import breakout_audio_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evt_wall,
  input  logic                       evt_brick,
  input  logic                       evt_paddle,
  input  logic                       evt_lose,
  input  logic                       mute,
  input  logic                       write_ready,
  output logic                       write,
  output logic signed [SAMPLE_W-1:0] writedata_left,
  output logic signed [SAMPLE_W-1:0] writedata_right,
  output logic                       busy
);

  sfx_state_e                 state, state_n;
  sfx_e                       cur, cur_n, new_sfx;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [ATT_W-1:0]           att, att_n;
  logic [N_EVT-1:0]           evt_vec, evt_q, edges;
  logic                       restart;
  logic signed [SAMPLE_W-1:0] osc_sample_c, wdata_n;

  assign write   = write_ready & ~reset;
  assign evt_vec = {evt_lose, evt_paddle, evt_brick, evt_wall};
  assign edges   = evt_vec & ~evt_q;

  // Priority encode: later assignments override, so the highest event wins.
  always_comb begin
    new_sfx = SFX_NONE;
    if (edges[0]) new_sfx = SFX_WALL;
    if (edges[1]) new_sfx = SFX_BRICK;
    if (edges[2]) new_sfx = SFX_PADDLE;
    if (edges[3]) new_sfx = SFX_LOSE;
  end

  // Next state: restart on equal/higher priority event, else sustain/release sequencing.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    att_n   = att;
    restart = 1'b0;
    if (new_sfx != SFX_NONE && (state == IDLE || new_sfx >= cur)) begin
      state_n = PLAY;
      cur_n   = new_sfx;
      cnt_n   = '0;
      att_n   = '0;
      restart = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (write_ready) begin
            if (cnt == sustain_len(cur) - CNT_W'(1)) begin
              state_n = RELEASE;
              cnt_n   = '0;
              att_n   = ATT_W'(1);
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (write_ready) begin
            if (cnt == CNT_W'(REL_STEP - 1)) begin
              cnt_n = '0;
              if (att == ATT_W'(ATT_MAX)) begin
                state_n = IDLE;
                cur_n   = SFX_NONE;
                att_n   = '0;
              end else begin
                att_n = att + ATT_W'(1);
              end
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  sfx_square_osc u_osc (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .adv      (write_ready && state != IDLE),
    .hp       (half_period(cur)),
    .att      (att_n),
    .sample_c (osc_sample_c)
  );

  assign wdata_n = (state_n == IDLE || mute) ? '0 : osc_sample_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cur             <= SFX_NONE;
      cnt             <= '0;
      att             <= '0;
      evt_q           <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      cur             <= cur_n;
      cnt             <= cnt_n;
      att             <= att_n;
      evt_q           <= evt_vec;
      writedata_left  <= wdata_n;
      writedata_right <= wdata_n;
      busy            <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Directed bench for sfx_tone_gen: tone shapes, handshake pacing, priority, mute, reset.
module tb_sfx_tone_gen;

  logic               clk = 1'b0;
  logic               reset, evt_wall, evt_brick, evt_paddle, evt_lose, mute, write_ready;
  logic               write, busy;
  logic signed [23:0] writedata_left, writedata_right;

  int n_checks = 0;
  int n_errors = 0;

  localparam int A = 1048576;

  int brick_k[12] = '{0, 23, 24, 47, 48, 4799, 4800, 5279, 5280, 5760, 6240, 6719};
  int brick_v[12] = '{A, A, -A, -A, A, -A, 524288, -524288, 262144, 131072, 65536, -65536};

  sfx_tone_gen dut (
    .clk             (clk),
    .reset           (reset),
    .evt_wall        (evt_wall),
    .evt_brick       (evt_brick),
    .evt_paddle      (evt_paddle),
    .evt_lose        (evt_lose),
    .mute            (mute),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int busy_clks;
    reset = 1'b1; evt_wall = 1'b0; evt_brick = 1'b0; evt_paddle = 1'b0; evt_lose = 1'b0;
    mute = 1'b0; write_ready = 1'b1;
    step(); step();
    check("rst_write", write, 0);
    check("rst_busy", busy, 0);
    check("rst_data", writedata_left, 0);
    reset = 1'b0;

    // Idle with constant ready.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (writedata_left !== 24'sd0 || busy !== 1'b0 || write !== 1'b1) bad++;
    end
    check("idle_1000", bad, 0);

    // Brick tone, full-rate ready.
    evt_brick = 1'b1; step(); evt_brick = 1'b0;
    bad = 0;
    for (int k = 0; k <= 6720; k++) begin
      for (int i = 0; i < 12; i++)
        if (brick_k[i] == k) check($sformatf("brick_k%0d", k), writedata_left, brick_v[i]);
      if (k == 6720) begin
        check("brick_busy_end", busy, 0);
        check("brick_data_end", writedata_left, 0);
      end else begin
        if (writedata_right !== writedata_left || busy !== 1'b1) bad++;
        step();
      end
    end
    check("brick_mirror_busy", bad, 0);

    // Brick tone with ready one cycle in four.
    write_ready = 1'b0;
    evt_brick = 1'b1; step(); evt_brick = 1'b0;
    busy_clks = 0;
    for (int j = 1; j <= 30000; j++) begin
      write_ready = (j % 4 == 0);
      #1;
      if (j == 4)   check("slow_write_hi", write, 1);
      if (j == 5)   check("slow_write_lo", write, 0);
      if (j == 96)  check("slow_j96", writedata_left, A);
      if (j == 100) check("slow_j100", writedata_left, -A);
      if (busy !== 1'b1) break;
      busy_clks++;
      step();
    end
    check("slow_busy_clks", busy_clks, 26880);
    write_ready = 1'b1;

    // Paddle tone: wall ignored, lose restarts.
    evt_paddle = 1'b1; step(); evt_paddle = 1'b0;
    repeat (59) step();
    evt_wall = 1'b1; step(); evt_wall = 1'b0;
    check("wall_ignored", writedata_left, -A);
    repeat (10) step();
    evt_lose = 1'b1; step(); evt_lose = 1'b0;
    check("lose_m0", writedata_left, A);
    repeat (119) step();
    check("lose_m119", writedata_left, A);
    step();
    check("lose_m120", writedata_left, -A);
    repeat (19079) step();
    check("lose_m19199", writedata_left, -A);
    step();
    check("lose_m19200", writedata_left, 524288);
    repeat (100) step();
    check("lose_m19300", writedata_left, 524288);

    // Reset mid-tone, event during reset ignored.
    reset = 1'b1; evt_brick = 1'b1; step();
    check("midrst_busy", busy, 0);
    check("midrst_data", writedata_left, 0);
    check("midrst_write", write, 0);
    evt_brick = 1'b0; step();
    reset = 1'b0; step(); step();
    check("postrst_busy", busy, 0);
    check("postrst_data", writedata_left, 0);

    // Simultaneous brick+paddle, paddle held high.
    evt_brick = 1'b1; evt_paddle = 1'b1; step(); evt_brick = 1'b0;
    busy_clks = 0;
    for (int k = 0; k < 10000; k++) begin
      if (k == 0)    check("pad_k0", writedata_left, A);
      if (k == 24)   check("pad_k24", writedata_left, A);
      if (k == 48)   check("pad_k48", writedata_left, -A);
      if (k == 6719) check("pad_k6719", writedata_left, -65536);
      if (k == 6720) check("pad_busy_6720", busy, 0);
      if (k == 9999) check("pad_held_busy", busy, 0);
      if (busy === 1'b1) busy_clks++;
      step();
    end
    evt_paddle = 1'b0;
    check("pad_busy_clks", busy_clks, 6720);
    step();

    // Mute mid-tone.
    evt_brick = 1'b1; step(); evt_brick = 1'b0;
    repeat (10) step();
    mute = 1'b1; step();
    check("mute_data", writedata_left, 0);
    check("mute_right", writedata_right, 0);
    check("mute_busy", busy, 1);
    repeat (89) step();
    mute = 1'b0; step();
    check("unmute_k101", writedata_left, A);
    repeat (6618) step();
    check("mute_busy_6719", busy, 1);
    step();
    check("mute_busy_6720", busy, 0);
    check("mute_data_6720", writedata_left, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
